// File: rtl/mode_sequencer_pkg.sv
// Shared types and helpers for the push-button mode sequencer.
// Holds the FSM state encoding, step directions and counter sizing helper.
package mode_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    AUTO     = 2'd2,
    WAIT_REL = 2'd3
  } seq_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/mode_sequencer_debounce.sv
// Button conditioner: 2-FF synchroniser followed by a stability counter.
// Reset assumes the button is held so a press spanning reset is not seen as a new edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1) + 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // A new level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Operating-mode selector: debounced next/prev buttons with hold-to-repeat,
// long-hold auto-cycling and a both-button clear to mode 0.
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int NUM_MODES        = 7,
  parameter int MODE_W           = 3,
  parameter int LED_W            = 4,
  parameter int DEBOUNCE_CYCLES  = 200000,
  parameter int REPEAT_CYCLES    = 8000000,
  parameter int AUTO_HOLD_CYCLES = 30000000,
  parameter int AUTO_STEP_CYCLES = 8000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_next,
  input  logic              btn_prev,
  output logic [MODE_W-1:0] mode,
  output logic [LED_W-1:0]  leds,
  output logic              auto_on,
  output logic              auto_dir,
  output logic              step_pulse
);

  if (NUM_MODES < 2 || NUM_MODES > (1 << MODE_W) || DEBOUNCE_CYCLES < 1 ||
      REPEAT_CYCLES < 1 || AUTO_HOLD_CYCLES < 1 || AUTO_STEP_CYCLES < 1) begin : g_param_check
    $error("mode_sequencer: illegal parameter combination");
  end

  localparam int CNT_W = $clog2(max3(REPEAT_CYCLES, AUTO_HOLD_CYCLES, AUTO_STEP_CYCLES)) + 1;
  localparam logic [MODE_W-1:0] LAST = MODE_W'(NUM_MODES - 1);

  function automatic logic [MODE_W-1:0] step_mode(input logic [MODE_W-1:0] cur, input logic dir);
    logic [MODE_W-1:0] res;
    if (dir == DIR_UP) begin
      res = (cur == LAST) ? '0 : cur + MODE_W'(1);
    end else begin
      res = (cur == '0) ? LAST : cur - MODE_W'(1);
    end
    return res;
  endfunction

  logic next_level, next_rise, prev_level, prev_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_next), .level(next_level), .rise(next_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_prev), .level(prev_level), .rise(prev_rise)
  );

  seq_state_t        state, state_nx;
  logic [MODE_W-1:0] mode_nx;
  logic              auto_on_nx, auto_dir_nx, held_dir, held_dir_nx, pulse_nx;
  logic [CNT_W-1:0]  hold_cnt, hold_nx, rep_cnt, rep_nx, auto_cnt, auto_nx;
  logic              do_step, step_dir, held_level, clear;

  // Next-state, step decision and counter updates.
  always_comb begin
    state_nx    = state;
    mode_nx     = mode;
    auto_on_nx  = auto_on;
    auto_dir_nx = auto_dir;
    held_dir_nx = held_dir;
    hold_nx     = hold_cnt;
    rep_nx      = rep_cnt;
    auto_nx     = auto_cnt;
    do_step     = 1'b0;
    step_dir    = held_dir;
    held_level  = (held_dir == DIR_UP) ? next_level : prev_level;
    clear       = (next_rise && prev_level) || (prev_rise && next_level);

    if (clear) begin
      mode_nx    = '0;
      auto_on_nx = 1'b0;
      state_nx   = WAIT_REL;
    end else begin
      case (state)
        IDLE: begin
          if (next_rise) begin
            do_step = 1'b1; step_dir = DIR_UP; held_dir_nx = DIR_UP; state_nx = HELD;
          end else if (prev_rise) begin
            do_step = 1'b1; step_dir = DIR_DOWN; held_dir_nx = DIR_DOWN; state_nx = HELD;
          end else begin
            state_nx = IDLE;
          end
        end
        HELD: begin
          if (!held_level) begin
            state_nx = IDLE;
          end else if (hold_cnt == CNT_W'(AUTO_HOLD_CYCLES - 1)) begin
            auto_on_nx = 1'b1; auto_dir_nx = held_dir; state_nx = WAIT_REL;
          end else begin
            hold_nx = hold_cnt + CNT_W'(1);
            if (rep_cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
              do_step = 1'b1; rep_nx = '0;
            end else begin
              rep_nx = rep_cnt + CNT_W'(1);
            end
          end
        end
        AUTO: begin
          if (next_rise || prev_rise) begin
            auto_on_nx = 1'b0; state_nx = WAIT_REL;
          end else if (auto_cnt == CNT_W'(AUTO_STEP_CYCLES - 1)) begin
            do_step = 1'b1; step_dir = auto_dir; auto_nx = '0;
          end else begin
            auto_nx = auto_cnt + CNT_W'(1);
          end
        end
        WAIT_REL: begin
          if (!next_level && !prev_level) begin
            state_nx = auto_on ? AUTO : IDLE;
          end else begin
            state_nx = WAIT_REL;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    // A step directly after a strobe is dropped so strobes never abut.
    if (do_step && !step_pulse) begin
      mode_nx = step_mode(mode, step_dir);
    end else begin
      mode_nx = mode_nx;
    end
    pulse_nx = (mode_nx != mode) && !step_pulse;

    if (state_nx != state) begin
      hold_nx = '0; rep_nx = '0; auto_nx = '0;
    end else begin
      hold_nx = hold_nx;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      mode       <= '0;
      leds       <= '0;
      auto_on    <= 1'b0;
      auto_dir   <= 1'b0;
      step_pulse <= 1'b0;
      held_dir   <= 1'b0;
      hold_cnt   <= '0;
      rep_cnt    <= '0;
      auto_cnt   <= '0;
    end else begin
      state      <= state_nx;
      mode       <= mode_nx;
      leds       <= LED_W'(mode);
      auto_on    <= auto_on_nx;
      auto_dir   <= auto_dir_nx;
      step_pulse <= pulse_nx;
      held_dir   <= held_dir_nx;
      hold_cnt   <= hold_nx;
      rep_cnt    <= rep_nx;
      auto_cnt   <= auto_nx;
    end
  end

endmodule
